// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read bus and buffer-swap handshake between the scanout
// engine and the framebuffer/renderer side.
//   fb_addr   : {buffer select, 15-bit pixel offset} read address
//   fb_rdata  : palette index, valid one cycle after fb_addr
//   swap_req  : request to exchange front and back buffers
//   swap_ack  : one-cycle pulse when the swap takes effect
//   front_buf : index of the buffer currently being scanned out
interface vga_fb_scanout_if;
    logic [15:0] fb_addr;
    logic [7:0]  fb_rdata;
    logic        swap_req;
    logic        swap_ack;
    logic        front_buf;

    modport master (
        output fb_addr,
        input  fb_rdata,
        input  swap_req,
        output swap_ack,
        output front_buf
    );

    modport slave (
        input  fb_addr,
        output fb_rdata,
        output swap_req,
        input  swap_ack,
        input  front_buf
    );
endinterface

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout: upscales a quarter-resolution, double-buffered,
// palettised framebuffer to the active area of the timing generator.
// Three-stage pipeline (address, RAM data, palette) with sync/enable
// delayed to stay aligned with colour.
//   clk_pix, rst_pix_n          : pixel clock, synchronous active-low reset
//   sx, sy, de, hsync, vsync    : timing generator position and syncs
//   frame                       : pulse on the last pixel of each frame
//   fb                          : framebuffer read bus + swap handshake
//   pal_we, pal_waddr, pal_wdata: palette write port {R,G,B} 4 bits each
//   vga_r/g/b, vga_hsync/vsync  : video out, 3 cycles after the inputs
module vga_fb_scanout #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned FB_W     = 200,
    parameter int unsigned FB_H     = 150
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic [9:0]              sx,
    input  logic [9:0]              sy,
    input  logic                    de,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic                    frame,
    vga_fb_scanout_if.master        fb,
    input  logic                    pal_we,
    input  logic [7:0]              pal_waddr,
    input  logic [11:0]             pal_wdata,
    output logic [3:0]              vga_r,
    output logic [3:0]              vga_g,
    output logic [3:0]              vga_b,
    output logic                    vga_hsync,
    output logic                    vga_vsync
);
    localparam logic [14:0] FB_STEP  = 15'(FB_W);
    localparam logic [14:0] LAST_ROW = 15'(FB_W * (FB_H - 1));
    localparam logic [9:0]  H_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_END    = 10'(V_ACTIVE);

    logic [14:0] line_base;
    logic [1:0]  sub;
    logic        pending;
    logic        front_q;
    logic        ack_q;
    logic [15:0] addr_q;
    logic [2:0]  de_d;
    logic [2:0]  hs_d;
    logic [2:0]  vs_d;
    logic [11:0] pal_mem [256];
    logic [11:0] pal_q;

    // Row tracking and buffer swap. Frame pulse resets the row and is the
    // only point where the front buffer may change.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            line_base <= '0;
            sub       <= '0;
            pending   <= 1'b0;
            front_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (frame) begin
                line_base <= '0;
                sub       <= '0;
                if (pending || fb.swap_req) begin
                    front_q <= ~front_q;
                    pending <= 1'b0;
                    ack_q   <= 1'b1;
                end
            end else begin
                if (fb.swap_req) begin
                    pending <= 1'b1;
                end
                if (sx == H_LAST && sy < V_END) begin
                    sub <= sub + 2'd1;
                    // Hold on the last row so the base never leaves the buffer
                    // between the final active line and the frame pulse.
                    if (sub == 2'd3 && line_base != LAST_ROW) begin
                        line_base <= line_base + FB_STEP;
                    end
                end
            end
        end
    end

    // Stage 1 address and the sync/enable delay line.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            addr_q <= '0;
            de_d   <= '0;
            hs_d   <= '1;
            vs_d   <= '1;
        end else begin
            addr_q <= {front_q, line_base + 15'(sx[9:2])};
            de_d   <= {de_d[1:0], de};
            hs_d   <= {hs_d[1:0], hsync};
            vs_d   <= {vs_d[1:0], vsync};
        end
    end

    // Palette RAM: no reset on contents; read-before-write on collision.
    always_ff @(posedge clk_pix) begin
        if (rst_pix_n && pal_we) begin
            pal_mem[pal_waddr] <= pal_wdata;
        end
        pal_q <= pal_mem[fb.fb_rdata];
    end

    assign fb.fb_addr   = addr_q;
    assign fb.front_buf = front_q;
    assign fb.swap_ack  = ack_q;

    assign vga_r     = de_d[2] ? pal_q[11:8] : '0;
    assign vga_g     = de_d[2] ? pal_q[7:4]  : '0;
    assign vga_b     = de_d[2] ? pal_q[3:0]  : '0;
    assign vga_hsync = hs_d[2];
    assign vga_vsync = vs_d[2];
endmodule
